calc_ctrl: RTL and testbench
============================

Name: calc_ctrl

Overview:
- Sequencing controller for the calculator's accumulate/display datapath.
- Conditions the two active-low push buttons `plus` and `equal`: synchronises, debounces and edge-detects them.
- Runs the entry FSM and issues one-cycle clear/load/add strobes to the accumulator.
- Selects what the 7-segment driver shows (live input or result) and keeps a sticky overflow flag from the datapath carry.

Parameters:
- WIDTH, 8: operand width; must match the `in` bus and the accumulator.
- DEBOUNCE_CYCLES, 4: consecutive stable synced cycles needed to accept a button level change; minimum 1.
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- plus  in  1  active-low "+" button, idles high, asynchronous to clk.
- equal  in  1  active-low "=" button, idles high, asynchronous to clk.
- acc_carry  in  1  carry-out of the datapath adder for the current add; valid in any cycle where acc_add=1.
- acc_clr  out  1  one-cycle pulse: accumulator <= 0.
- acc_load  out  1  one-cycle pulse: accumulator <= in.
- acc_add  out  1  one-cycle pulse: accumulator <= accumulator + in, mod 2^WIDTH.
- disp_sel  out  1  0 = display `in`; 1 = display accumulator.
- ovf  out  1  sticky overflow: some add since the last load/clr produced a carry.
- state_o  out  2  current FSM state, for debug and the bench.

Behaviour:
- Reset:
  - Outputs: all strobes 0, disp_sel 0, ovf 0, state IDLE.
  - Internal: synchroniser and debounced levels preset to 1 (released); debounce counters 0.
  - Asserting reset mid-operation aborts any half-finished entry immediately.
- Button conditioning (each button independently):
  - 2-flop synchroniser.
  - Counter increments while the synced level differs from the debounced level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - A press event is a debounced 1->0 transition, one cycle wide. Release (0->1) produces no event.
  - A glitch shorter than DEBOUNCE_CYCLES yields no event.
- Event-to-strobe latency:
  - The strobe is registered and appears in the cycle after the press event.
  - Total: the strobe is high DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the button low.
- Simultaneous events: if plus and equal events fall in the same cycle, equal wins and the plus event is discarded.
- FSM. States: IDLE=0 (showing input, nothing stored), OPER=1 (first operand stored, entering the next), SHOW=2 (result shown). Encoding 3 is illegal and recovers to IDLE with no strobe. Transitions:
  - IDLE, plus: acc_load -> OPER; disp_sel=0.
  - IDLE, equal: acc_load -> SHOW; disp_sel=1.
  - OPER, plus: acc_add, stay in OPER (chained sum); disp_sel=0.
  - OPER, equal: acc_add -> SHOW; disp_sel=1.
  - SHOW, plus: acc_load -> OPER; disp_sel=0. A new calculation starts from `in`; the old result is not chained.
  - SHOW, equal: no strobe, stay in SHOW.
  - No event: hold state, all strobes 0.
- Strobe rules: at most one of acc_clr/acc_load/acc_add is high per cycle. acc_clr fires only in the first cycle after reset deasserts, so the accumulator is 0 at start.
- disp_sel is registered and changes in the same cycle as the strobe that causes the transition.
- ovf:
  - Set in the cycle after an acc_add where acc_carry=1.
  - Cleared by acc_load or acc_clr.
  - Unchanged otherwise, including in SHOW.
- Wrap-around: the sum wraps mod 2^WIDTH in the datapath; the controller only flags it through ovf.
- Holding a button: produces exactly one event until it is released and pressed again.

Decomposition:
- calc_pkg holds:
  - state enum ctrl_state_t {IDLE, OPER, SHOW};
  - defaults for WIDTH and DEBOUNCE_CYCLES.
- Sub-module calc_btn_debounce (synchroniser, counter, debounced level, press pulse), parameterised by DEBOUNCE_CYCLES/CNT_W and instantiated once per button.
- The FSM, strobes, disp_sel and ovf live in calc_ctrl.

Test Plan:
- Reset release: exactly one acc_clr pulse, state_o=0, disp_sel=0, ovf=0; no further strobes with buttons held high for 50 cycles.
- Add 15 + 2 with DEBOUNCE_CYCLES=4:
  - in=15, press plus -> acc_load 7 edges after the first low sample, state OPER, disp_sel=0.
  - in=2, press equal -> acc_add, state SHOW, disp_sel=1; datapath shows 17, ovf=0.
- New calculation from SHOW: in=7, plus -> acc_load (not acc_add), state OPER; in=3, equal -> acc_add, SHOW; result 10.
- Overflow: in=200, plus; in=100, equal with acc_carry=1 -> ovf=1 in SHOW (result 44); next plus load clears ovf to 0.
- Debounce and hold:
  - a 3-cycle low glitch on plus (DEBOUNCE_CYCLES=4) -> no strobe;
  - plus held low for 100 cycles -> exactly one strobe;
  - equal pressed in SHOW -> no strobe.
- Simultaneous presses and mid-operation reset:
  - plus and equal fall in the same cycle in OPER -> a single acc_add and SHOW;
  - reset asserted in OPER -> outputs return to reset values asynchronously, then one acc_clr after deassertion.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and default parameters for the calculator control slice.
package calc_pkg;

    localparam int CALC_WIDTH    = 8;
    localparam int CALC_DEBOUNCE = 4;
    localparam int CALC_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        SHOW = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/calc_btn_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle press pulse on each accepted 1->0 change.
module calc_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press_o
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // The DEBOUNCE_CYCLES-th consecutive differing sample accepts the new level.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d    = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: button conditioning, entry FSM,
// accumulator strobes, display select and sticky overflow.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH           = CALC_WIDTH,
    parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE,
    parameter int CNT_W           = CALC_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       plus,
    input  logic       equal,
    input  logic       acc_carry,
    output logic       acc_clr,
    output logic       acc_load,
    output logic       acc_add,
    output logic       disp_sel,
    output logic       ovf,
    output logic [1:0] state_o
);

    if (WIDTH < 1 || DEBOUNCE_CYCLES < 1 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("calc_ctrl: illegal WIDTH/DEBOUNCE_CYCLES/CNT_W combination");
    end

    logic plus_ev, equal_ev;

    calc_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_plus_db (
        .clk(clk), .reset(reset), .btn_n(plus), .press_o(plus_ev)
    );

    calc_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_equal_db (
        .clk(clk), .reset(reset), .btn_n(equal), .press_o(equal_ev)
    );

    ctrl_state_t state_q, state_d;
    logic        clr_pend_q, clr_pend_d;
    logic        acc_clr_q, acc_clr_d;
    logic        acc_load_q, acc_load_d;
    logic        acc_add_q, acc_add_d;
    logic        disp_sel_q, disp_sel_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        state_d    = state_q;
        clr_pend_d = 1'b0;
        acc_clr_d  = 1'b0;
        acc_load_d = 1'b0;
        acc_add_d  = 1'b0;
        disp_sel_d = disp_sel_q;
        ovf_d      = ovf_q;
        if (acc_add_q && acc_carry) ovf_d = 1'b1;

        // The clear is issued once after reset; no event can be debounced that early.
        if (clr_pend_q) begin
            acc_clr_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (equal_ev) begin
                        acc_load_d = 1'b1;
                        state_d    = SHOW;
                        disp_sel_d = 1'b1;
                    end else if (plus_ev) begin
                        acc_load_d = 1'b1;
                        state_d    = OPER;
                        disp_sel_d = 1'b0;
                    end
                end
                OPER: begin
                    if (equal_ev) begin
                        acc_add_d  = 1'b1;
                        state_d    = SHOW;
                        disp_sel_d = 1'b1;
                    end else if (plus_ev) begin
                        acc_add_d  = 1'b1;
                        disp_sel_d = 1'b0;
                    end
                end
                SHOW: begin
                    if (plus_ev && !equal_ev) begin
                        acc_load_d = 1'b1;
                        state_d    = OPER;
                        disp_sel_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    disp_sel_d = 1'b0;
                end
            endcase
        end

        if (acc_load_d || acc_clr_d) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_pend_q <= 1'b1;
            acc_clr_q  <= 1'b0;
            acc_load_q <= 1'b0;
            acc_add_q  <= 1'b0;
            disp_sel_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            acc_clr_q  <= acc_clr_d;
            acc_load_q <= acc_load_d;
            acc_add_q  <= acc_add_d;
            disp_sel_q <= disp_sel_d;
            ovf_q      <= ovf_d;
        end
    end

    assign acc_clr  = acc_clr_q;
    assign acc_load = acc_load_q;
    assign acc_add  = acc_add_q;
    assign disp_sel = disp_sel_q;
    assign ovf      = ovf_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a small accumulator model standing in for the datapath.
module tb_calc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       plus;
    logic       equal;
    logic       acc_carry;
    logic       acc_clr, acc_load, acc_add;
    logic       disp_sel, ovf;
    logic [1:0] state_o;

    logic [7:0] in_val;
    logic [7:0] acc;
    logic [8:0] sum9;

    int n_checks = 0;
    int n_errors = 0;
    int n_clr = 0, n_load = 0, n_add = 0, n_multi = 0;

    calc_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .plus(plus), .equal(equal),
        .acc_carry(acc_carry), .acc_clr(acc_clr), .acc_load(acc_load),
        .acc_add(acc_add), .disp_sel(disp_sel), .ovf(ovf), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign sum9      = {1'b0, acc} + {1'b0, in_val};
    assign acc_carry = sum9[8];

    always @(posedge clk) begin
        if (acc_clr)       acc <= 8'd0;
        else if (acc_load) acc <= in_val;
        else if (acc_add)  acc <= sum9[7:0];
        if (acc_clr)  n_clr++;
        if (acc_load) n_load++;
        if (acc_add)  n_add++;
        if ((32'(acc_clr) + 32'(acc_load) + 32'(acc_add)) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input bit p, input bit e, input int hold);
        @(negedge clk);
        plus  = p ? 1'b0 : 1'b1;
        equal = e ? 1'b0 : 1'b1;
        repeat (hold) @(negedge clk);
        plus  = 1'b1;
        equal = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    int l0, a0, c0;

    initial begin
        reset  = 1'b1;
        plus   = 1'b1;
        equal  = 1'b1;
        in_val = 8'd0;
        acc    = 8'hxx;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_o), 0);
        check("rst_disp", 32'(disp_sel), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_strobes", {29'd0, acc_clr, acc_load, acc_add}, 0);

        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("init_clr_count", 32'(n_clr), 1);
        check("init_load_count", 32'(n_load), 0);
        check("init_add_count", 32'(n_add), 0);
        check("init_acc", 32'(acc), 0);
        check("init_state", 32'(state_o), 0);

        // 15 + 2, with load latency of DEBOUNCE_CYCLES+3 = 7 edges
        in_val = 8'd15;
        plus = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("lat_edge6_load", 32'(acc_load), 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_edge7_load", 32'(acc_load), 1);
        check("load_state", 32'(state_o), 1);
        check("load_disp", 32'(disp_sel), 0);
        repeat (5) @(negedge clk);
        plus = 1'b1;
        repeat (12) @(negedge clk);
        check("acc_15", 32'(acc), 15);

        in_val = 8'd2;
        press(0, 1, 10);
        check("sum_state", 32'(state_o), 2);
        check("sum_disp", 32'(disp_sel), 1);
        check("sum_acc", 32'(acc), 17);
        check("sum_ovf", 32'(ovf), 0);
        check("sum_adds", 32'(n_add), 1);

        // new calculation from SHOW: 7 + 3
        l0 = n_load; a0 = n_add;
        in_val = 8'd7;
        press(1, 0, 10);
        check("new_load", 32'(n_load - l0), 1);
        check("new_noadd", 32'(n_add - a0), 0);
        check("new_state", 32'(state_o), 1);
        check("new_disp", 32'(disp_sel), 0);
        in_val = 8'd3;
        press(0, 1, 10);
        check("new_state2", 32'(state_o), 2);
        check("new_acc", 32'(acc), 10);

        // overflow: 200 + 100 = 300 -> 44 with carry
        in_val = 8'd200;
        press(1, 0, 10);
        in_val = 8'd100;
        press(0, 1, 10);
        check("ovf_state", 32'(state_o), 2);
        check("ovf_acc", 32'(acc), 44);
        check("ovf_set", 32'(ovf), 1);
        in_val = 8'd5;
        press(1, 0, 10);
        check("ovf_cleared", 32'(ovf), 0);
        check("ovf_state2", 32'(state_o), 1);
        check("ovf_acc2", 32'(acc), 5);

        // glitch and long hold in OPER
        l0 = n_load; a0 = n_add; c0 = n_clr;
        press(1, 0, 3);
        check("glitch_strobes", 32'((n_load - l0) + (n_add - a0) + (n_clr - c0)), 0);
        check("glitch_state", 32'(state_o), 1);
        in_val = 8'd1;
        press(1, 0, 100);
        check("hold_adds", 32'(n_add - a0), 1);
        check("hold_acc", 32'(acc), 6);
        press(0, 1, 10);
        check("hold_show", 32'(state_o), 2);
        l0 = n_load; a0 = n_add;
        press(0, 1, 10);
        check("show_eq_strobes", 32'((n_load - l0) + (n_add - a0)), 0);
        check("show_eq_state", 32'(state_o), 2);

        // simultaneous presses in OPER
        in_val = 8'd4;
        press(1, 0, 10);
        l0 = n_load; a0 = n_add;
        in_val = 8'd9;
        press(1, 1, 10);
        check("simul_add", 32'(n_add - a0), 1);
        check("simul_noload", 32'(n_load - l0), 0);
        check("simul_state", 32'(state_o), 2);
        check("simul_acc", 32'(acc), 13);

        // mid-operation reset with ovf set in OPER
        in_val = 8'd200;
        press(1, 0, 10);
        in_val = 8'd100;
        press(1, 0, 10);
        check("pre_rst_state", 32'(state_o), 1);
        check("pre_rst_ovf", 32'(ovf), 1);
        c0 = n_clr;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_state", 32'(state_o), 0);
        check("async_ovf", 32'(ovf), 0);
        check("async_disp", 32'(disp_sel), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rerst_clr", 32'(n_clr - c0), 1);
        check("rerst_acc", 32'(acc), 0);
        check("onehot", 32'(n_multi), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
